// File: rtl/data_mem_responder.sv
// Single-port 64-bit data memory responder: accepts one request, waits LATENCY cycles, then
// holds the response until taken. Optional address fault checking via DMEM_ERR_CHECK_EN.
module data_mem_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    input  logic        rsp_ready
);

    localparam int unsigned Words    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WaitLoad = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        error_q;

    logic [63:0] mem [Words];

    logic                  enter_resp;
    logic                  acc_write;
    logic [63:0]           acc_addr;
    logic [63:0]           acc_wdata;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_err;

    // With zero latency the access completes on the accepting edge, so use the live request.
    always_comb begin
        if (state_q == StIdle) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_idx    = acc_addr[DEPTH_LOG2+2:3];
        enter_resp = ((state_q == StIdle) && req_valid && (LATENCY == 0)) ||
                     ((state_q == StBusy) && (cnt_q == 4'd0));
    end

`ifdef DMEM_ERR_CHECK_EN
    assign acc_err = (acc_addr[2:0] != 3'd0) || (acc_addr[63:DEPTH_LOG2+3] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[63:DEPTH_LOG2+3], acc_addr[2:0]};
    assign acc_err          = 1'b0;
`endif

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (LATENCY == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StBusy;
                            cnt_q   <= WaitLoad;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                        rdata_q <= '0;
                        error_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (enter_resp) begin
                rdata_q <= (acc_write || acc_err) ? 64'd0 : mem[acc_idx];
                error_q <= acc_err;
            end
        end
    end

    // Array is never reset; resetl gating keeps an abandoned store from landing.
    always_ff @(posedge CLK) begin
        if (resetl && enter_resp && acc_write && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, hold/reset sequences and
// randomized traffic against a word-array reference model. Honours DMEM_ERR_CHECK_EN.
module tb_data_mem_responder;

    localparam int unsigned Lat = 2;
    localparam int unsigned Dl2 = 6;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_ready;

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [int unsigned];

    data_mem_responder #(
        .LATENCY    (Lat),
        .DEPTH_LOG2 (Dl2)
    ) dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .rsp_ready (rsp_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_err(input logic [63:0] a);
`ifdef DMEM_ERR_CHECK_EN
        return (a % 8 != 0) || ((a >> (Dl2 + 3)) != 0);
`else
        return 1'b0 & a[0];
`endif
    endfunction

    // Reference: the store is applied at once; a load returns the last value written to its word.
    task automatic model(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] exp_d, output bit exp_e, output bit known);
        int unsigned idx;
        idx   = int'((a / 8) % (64'd1 << Dl2));
        exp_e = addr_err(a);
        exp_d = 64'd0;
        known = 1'b1;
        if (wr) begin
            if (!exp_e) ref_mem[idx] = wd;
        end else if (!exp_e) begin
            if (ref_mem.exists(idx)) exp_d = ref_mem[idx];
            else known = 1'b0;
        end
    endtask

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    // Caller is between edges with the DUT idle; returns between edges with the DUT idle.
    task automatic txn(input bit wr, input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_d, input bit exp_e, input bit known,
                       input int hold, input bit spam);
        int n;
        chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        scramble_req();
        chk("req_ready_after_accept", {63'd0, req_ready}, 64'd0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(Lat));
        if (!rsp_valid) return;
        chk("rsp_error", {63'd0, rsp_error}, {63'd0, exp_e});
        if (known) chk("rsp_rdata", rsp_rdata, exp_d);
        for (int i = 0; i < hold; i++) begin
            if (spam) begin
                req_valid = 1'($urandom);
                scramble_req();
            end
            @(posedge CLK);
            #1;
            chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
            chk("hold_rsp_error", {63'd0, rsp_error}, {63'd0, exp_e});
            if (known) chk("hold_rsp_rdata", rsp_rdata, exp_d);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("done_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("done_req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_d;
        bit          exp_e;
    } vec_t;

    localparam logic [63:0] D0 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] DA = 64'hA5A5_A5A5_5A5A_5A5A;
    localparam logic [63:0] DB = 64'h0123_4567_89AB_CDEF;

    initial begin
        vec_t        tbl[10];
        logic [63:0] md;
        bit          me;
        bit          mk;

        tbl[0] = '{1'b1, 64'h0,  DA,    64'h0, 1'b0};
        tbl[1] = '{1'b1, 64'h10, D0,    64'h0, 1'b0};
        tbl[2] = '{1'b0, 64'h10, 64'h0, D0,    1'b0};
        tbl[3] = '{1'b1, 64'h08, DB,    64'h0, 1'b0};
        tbl[4] = '{1'b0, 64'h08, 64'h0, DB,    1'b0};
        tbl[8] = '{1'b1, 64'h18, 64'h77, 64'h0, 1'b0};
`ifdef DMEM_ERR_CHECK_EN
        tbl[5] = '{1'b1, 64'h14, 64'h1, 64'h0, 1'b1};
        tbl[6] = '{1'b0, 64'h10, 64'h0, D0,    1'b0};
        tbl[7] = '{1'b0, 64'h200, 64'h0, 64'h0, 1'b1};
        tbl[9] = '{1'b0, 64'h1000_0000_0000_0018, 64'h0, 64'h0, 1'b1};
`else
        tbl[5] = '{1'b1, 64'h14, 64'h1, 64'h0, 1'b0};
        tbl[6] = '{1'b0, 64'h10, 64'h0, 64'h1, 1'b0};
        tbl[7] = '{1'b0, 64'h200, 64'h0, DA,   1'b0};
        tbl[9] = '{1'b0, 64'h1000_0000_0000_0018, 64'h0, 64'h77, 1'b0};
`endif

        resetl    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #3;
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_error", {63'd0, rsp_error}, 64'd0);
        #5;
        resetl = 1'b1;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) begin
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, md, me, mk);
            txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_d, tbl[i].exp_e, 1'b1, 0, 1'b0);
        end

        // Long hold with noisy req_valid; a following load proves the noise wrote nothing.
        model(1'b0, 64'h08, 64'h0, md, me, mk);
        txn(1'b0, 64'h08, 64'h0, DB, 1'b0, 1'b1, 5, 1'b1);
        model(1'b0, 64'h08, 64'h0, md, me, mk);
        txn(1'b0, 64'h08, 64'h0, DB, 1'b0, 1'b1, 0, 1'b0);

        // Reset pulse right after accepting a store: outputs clear at once, store is dropped.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h18;
        req_wdata = 64'h55;
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        #2;
        resetl = 1'b0;
        #1;
        chk("midreset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("midreset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("midreset_rsp_rdata", rsp_rdata, 64'd0);
        chk("midreset_rsp_error", {63'd0, rsp_error}, 64'd0);
        #1;
        resetl = 1'b1;
        if (Lat == 0) ref_mem[3] = 64'h55;
        model(1'b0, 64'h18, 64'h0, md, me, mk);
        txn(1'b0, 64'h18, 64'h0, md, me, mk, 0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            bit          wr;
            logic [63:0] a;
            logic [63:0] wd;
            int unsigned r;
            wr = 1'($urandom);
            a  = 64'($urandom_range(0, 63)) * 8;
            r  = $urandom_range(0, 7);
            if (r == 0) a[2:0] = 3'($urandom_range(1, 7));
            if (r == 1) a[40] = 1'b1;
            wd = {$urandom, $urandom};
            model(wr, a, wd, md, me, mk);
            txn(wr, a, wd, md, me, mk, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
